alu_mc: RTL

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_mc_pkg.sv | 27 ++
 rtl/alu_mc_div.sv | 58 +++++
 rtl/alu_mc.sv | 122 ++++++++++++
 3 files changed

// File: rtl/alu_mc_pkg.sv
// Shared opcode encodings and FSM state type for the multi-cycle ALU.
package alu_mc_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_SHL  = 4'd4;
  localparam logic [3:0] OP_SHR  = 4'd5;
  localparam logic [3:0] OP_ROL  = 4'd6;
  localparam logic [3:0] OP_ROR  = 4'd7;
  localparam logic [3:0] OP_AND  = 4'd8;
  localparam logic [3:0] OP_OR   = 4'd9;
  localparam logic [3:0] OP_XOR  = 4'd10;
  localparam logic [3:0] OP_NOR  = 4'd11;
  localparam logic [3:0] OP_NAND = 4'd12;
  localparam logic [3:0] OP_XNOR = 4'd13;
  localparam logic [3:0] OP_EQ   = 4'd14;
  localparam logic [3:0] OP_GT   = 4'd15;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_BUSY = 2'd1,
    DONE     = 2'd2
  } state_t;

endpackage

// File: rtl/alu_mc_div.sv
// Iterative restoring divider, one quotient bit per clock; only built with ALU_MC_DIV_EN.
// done pulses combinationally in the last iteration cycle with the final quotient.
`ifdef ALU_MC_DIV_EN
module alu_mc_div #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             busy;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem, quo, dvs;
  logic [WIDTH:0]   r_sh, diff;
  logic             ge;
  logic [WIDTH-1:0] rem_n, quo_n;

  always_comb begin
    r_sh  = {rem, quo[WIDTH-1]};
    diff  = r_sh - {1'b0, dvs};
    ge    = (r_sh >= {1'b0, dvs});
    // when the subtraction is skipped r_sh < divisor, so it fits in WIDTH bits
    rem_n = ge ? diff[WIDTH-1:0] : r_sh[WIDTH-1:0];
    quo_n = {quo[WIDTH-2:0], ge};
  end

  assign done     = busy && (cnt == CW'(1));
  assign quotient = quo_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= '0;
      rem  <= '0;
      quo  <= '0;
      dvs  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= CW'(WIDTH);
      rem  <= '0;
      quo  <= dividend;
      dvs  <= divisor;
    end else if (busy) begin
      rem <= rem_n;
      quo <= quo_n;
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) busy <= 1'b0;
    end
  end

endmodule
`endif

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes. Define ALU_MC_DIV_EN to build the
// iterative divider; otherwise DIV always reports divide-by-zero in one cycle.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SEL_W-1:0] select,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   z,
  output logic             flag_zero,
  output logic             flag_err
);
  state_t state, nstate;

  logic             accept, div_go, div_done;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH:0]   alu_z;
  logic             alu_err;
  logic [2*WIDTH-1:0] prod;

  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);

`ifdef ALU_MC_DIV_EN
  assign div_go = accept && (select == OP_DIV) && (b != '0);

  alu_mc_div #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_go),
    .dividend (a),
    .divisor  (b),
    .done     (div_done),
    .quotient (div_q)
  );
`else
  assign div_go   = 1'b0;
  assign div_done = 1'b0;
  assign div_q    = '0;
`endif

  assign prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  // Single-cycle datapath; DIV here is the divide-by-zero (or divider-less) result.
  always_comb begin
    alu_z   = '0;
    alu_err = 1'b0;
    case (select)
      OP_ADD:  alu_z = {1'b0, a} + {1'b0, b};
      OP_SUB:  alu_z = {(a < b), a - b};
      OP_MUL:  alu_z = {|prod[2*WIDTH-1:WIDTH], prod[WIDTH-1:0]};
      OP_DIV:  begin
        alu_z   = {1'b0, {WIDTH{1'b1}}};
        alu_err = 1'b1;
      end
      OP_SHL:  alu_z = {a, 1'b0};
      OP_SHR:  alu_z = {2'b00, a[WIDTH-1:1]};
      OP_ROL:  alu_z = {1'b0, a[WIDTH-2:0], a[WIDTH-1]};
      OP_ROR:  alu_z = {1'b0, a[0], a[WIDTH-1:1]};
      OP_AND:  alu_z = {1'b0, a & b};
      OP_OR:   alu_z = {1'b0, a | b};
      OP_XOR:  alu_z = {1'b0, a ^ b};
      OP_NOR:  alu_z = {1'b0, ~(a | b)};
      OP_NAND: alu_z = {1'b0, ~(a & b)};
      OP_XNOR: alu_z = {1'b0, ~(a ^ b)};
      OP_EQ:   alu_z = {{WIDTH{1'b0}}, (a == b)};
      OP_GT:   alu_z = {{WIDTH{1'b0}}, (a > b)};
      default: alu_z = '0;
    endcase
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:     if (in_valid) nstate = div_go ? DIV_BUSY : DONE;
      DIV_BUSY: begin
`ifdef ALU_MC_DIV_EN
        if (div_done) nstate = DONE;
`else
        nstate = IDLE;
`endif
      end
      DONE:     if (out_ready) begin
        if (in_valid) nstate = div_go ? DIV_BUSY : DONE;
        else          nstate = IDLE;
      end
      default:  nstate = IDLE;
    endcase
  end

  // flag_zero is registered so it reads 0 under reset even though z does too.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      z         <= '0;
      flag_zero <= 1'b0;
      flag_err  <= 1'b0;
    end else begin
      state <= nstate;
      if (accept && !div_go) begin
        z         <= alu_z;
        flag_zero <= (alu_z[WIDTH-1:0] == '0);
        flag_err  <= alu_err;
      end else if (div_done) begin
        z         <= {1'b0, div_q};
        flag_zero <= (div_q == '0);
        flag_err  <= 1'b0;
      end
    end
  end

endmodule
